ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, cycles allowed in BUSY before a watchdog abort (used only with RAM_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 reqRead  input  2  per-requester read request; bit0 = decompressor, bit1 = CNN/loader.
REQ-005 reqWrite  input  2  per-requester write request, same bit mapping.
REQ-006 reqAddress  input  32  requester addresses; [15:0] = req0, [31:16] = req1.
REQ-007 reqDataIn  input  16  requester write data; [7:0] = req0, [15:8] = req1.
REQ-008 grant  output  2  one-hot owner of the RAM path; 0 when idle.
REQ-009 reqDone  output  2  one-cycle completion pulse to the owning requester.
REQ-010 reqDataOut  output  8  read data; valid in the cycle reqDone pulses.
REQ-011 ramAddress  output  16  address to DMA.
REQ-012 ramDataIn  output  8  write data to DMA.
REQ-013 ramReadSignal, ramWriteSignal  output  1 each  DMA strobes, level-held until done.
REQ-014 ramDataOut  input  8  DMA read data.
REQ-015 ramDoneRead, ramDoneWrite  input  1 each  DMA completion.
REQ-016 timeoutErr  output  1  sticky watchdog flag (0 when feature compiled out).

Function
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 A requester is pending when its reqRead or reqWrite bit is 1; if both are 1, it is a read and the write is ignored.
REQ-019 IDLE, one pending: grant it; IDLE, both pending: grant the requester not served last (round-robin pointer, 0 after reset, so req0 wins first).
REQ-020 On IDLE->BUSY, latch the winner's address, data and op; set grant; next cycle drive ramAddress/ramDataIn and the matching strobe.
REQ-021 BUSY: hold strobe, address and data stable; on ramDoneRead (read) or ramDoneWrite (write), capture ramDataOut for reads and go to DONE; a done of the wrong type is ignored.
REQ-022 DONE: drop strobes, pulse reqDone[owner] for exactly one cycle with reqDataOut valid, flip the round-robin pointer to the owner, clear grant, go to IDLE.
REQ-023 Latency: request sampled in cycle 0 -> strobe high in cycle 1; DMA done in cycle k -> reqDone in cycle k+1; a new grant is possible no earlier than cycle k+2.
REQ-024 Requests deasserting during BUSY do not abort; the transaction completes and reqDone still pulses.
REQ-025 Requesters hold requests until reqDone; a request still held after reqDone is treated as a new transaction.
REQ-026 reqDataOut holds its last captured value between reads; ramDataIn and ramAddress hold their last values while IDLE.
REQ-027 At most one strobe is high at any time; strobes are never high in IDLE or DONE.

Reset
REQ-028 RST low asynchronously forces IDLE, pointer=0, grant=0, reqDone=0, strobes=0, ramAddress=0, ramDataIn=0, reqDataOut=0, timeoutErr=0, watchdog=0.
REQ-029 Reset mid-BUSY drops the strobe immediately; the transaction is lost and no reqDone is issued.

Configuration
REQ-030 Macro RAM_ARB_TIMEOUT_EN defined: BUSY counts cycles; reaching TIMEOUT_CYCLES with no matching done drops strobes, sets timeoutErr (sticky until reset), pulses reqDone[owner] with reqDataOut=8'h00, returns to IDLE through DONE.
REQ-031 Macro undefined: no counter; BUSY waits indefinitely; timeoutErr tied 0.

Verification
REQ-032 req0 read addr 16'h0010, DMA returns 8'hA5 after 3 cycles -> ramReadSignal high cycles 1-3, reqDone=2'b01 in cycle 4, reqDataOut=8'hA5.
REQ-033 req0 and req1 write simultaneously from reset -> req0 served first, then req1; grant sequence 01, 00, 10.
REQ-034 Both requesters keep requesting continuously -> grants alternate 01/10; neither starves across 8 transactions.
REQ-035 req1 sets reqRead and reqWrite together, addr 16'h1234 -> only ramReadSignal asserts, at ramAddress=16'h1234.
REQ-036 RST pulled low during BUSY -> strobe low in the same cycle, no reqDone, next request starts from a clean IDLE.
REQ-037 With RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, DMA never responds -> strobe drops after 4 BUSY cycles, timeoutErr=1, reqDone pulses with reqDataOut=8'h00.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter in front of a byte-wide DMA RAM port
// Optional watchdog abort of stalled transfers: define RAM_ARB_TIMEOUT_EN.
module ram_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [1:0]  reqRead,
    input  logic [1:0]  reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [15:0] reqDataIn,
    output logic [1:0]  grant,
    output logic [1:0]  reqDone,
    output logic [7:0]  reqDataOut,
    output logic [15:0] ramAddress,
    output logic [7:0]  ramDataIn,
    output logic        ramReadSignal,
    output logic        ramWriteSignal,
    input  logic [7:0]  ramDataOut,
    input  logic        ramDoneRead,
    input  logic        ramDoneWrite,
    output logic        timeoutErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_ptr;      // requester that wins when both are pending
    logic r_owner;
    logic r_is_read;

    logic w_pend0;
    logic w_pend1;
    logic w_any;
    logic w_win;
    logic w_win_read;
    logic w_match;
    logic w_timeout;

    assign w_pend0    = reqRead[0] | reqWrite[0];
    assign w_pend1    = reqRead[1] | reqWrite[1];
    assign w_any      = w_pend0 | w_pend1;
    assign w_win      = (w_pend0 & w_pend1) ? r_ptr : w_pend1;
    assign w_win_read = reqRead[w_win];
    assign w_match    = r_is_read ? ramDoneRead : ramDoneWrite;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;

    assign w_timeout  = (r_state == S_BUSY) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeoutErr = r_timeout_err;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_timeout && !w_match) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout  = 1'b0;
    // Constant zero; the parameter only matters when the watchdog is built in.
    assign timeoutErr = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_BUSY;
            S_BUSY:  if (w_match || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_ptr          <= 1'b0;
            r_owner        <= 1'b0;
            r_is_read      <= 1'b0;
            grant          <= 2'b00;
            reqDone        <= 2'b00;
            reqDataOut     <= 8'h00;
            ramAddress     <= 16'h0000;
            ramDataIn      <= 8'h00;
            ramReadSignal  <= 1'b0;
            ramWriteSignal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner        <= w_win;
                        r_is_read      <= w_win_read;
                        grant          <= w_win ? 2'b10 : 2'b01;
                        ramAddress     <= w_win ? reqAddress[31:16] : reqAddress[15:0];
                        ramDataIn      <= w_win ? reqDataIn[15:8] : reqDataIn[7:0];
                        ramReadSignal  <= w_win_read;
                        ramWriteSignal <= ~w_win_read;
                    end
                end
                S_BUSY: begin
                    if (w_match || w_timeout) begin
                        ramReadSignal  <= 1'b0;
                        ramWriteSignal <= 1'b0;
                        reqDone        <= r_owner ? 2'b10 : 2'b01;
                        // A matching done beats a coincident watchdog expiry.
                        if (w_match) begin
                            if (r_is_read) reqDataOut <= ramDataOut;
                        end else begin
                            reqDataOut <= 8'h00;
                        end
                    end
                end
                S_DONE: begin
                    reqDone <= 2'b00;
                    grant   <= 2'b00;
                    r_ptr   <= ~r_owner;
                end
                default: begin
                    ramReadSignal  <= 1'b0;
                    ramWriteSignal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  reqRead = 2'b00;
    logic [1:0]  reqWrite = 2'b00;
    logic [31:0] reqAddress = 32'h0;
    logic [15:0] reqDataIn = 16'h0;
    logic [1:0]  grant;
    logic [1:0]  reqDone;
    logic [7:0]  reqDataOut;
    logic [15:0] ramAddress;
    logic [7:0]  ramDataIn;
    logic        ramReadSignal;
    logic        ramWriteSignal;
    logic [7:0]  ramDataOut = 8'h00;
    logic        ramDoneRead = 1'b0;
    logic        ramDoneWrite = 1'b0;
    logic        timeoutErr;

    int vectors = 0;
    int errors  = 0;
    int served0 = 0;
    int served1 = 0;

    ram_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk            (clk),
        .RST            (RST),
        .reqRead        (reqRead),
        .reqWrite       (reqWrite),
        .reqAddress     (reqAddress),
        .reqDataIn      (reqDataIn),
        .grant          (grant),
        .reqDone        (reqDone),
        .reqDataOut     (reqDataOut),
        .ramAddress     (ramAddress),
        .ramDataIn      (ramDataIn),
        .ramReadSignal  (ramReadSignal),
        .ramWriteSignal (ramWriteSignal),
        .ramDataOut     (ramDataOut),
        .ramDoneRead    (ramDoneRead),
        .ramDoneWrite   (ramDoneWrite),
        .timeoutErr     (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        #1;
        check("rst_grant", {30'd0, grant}, 32'h0);
        check("rst_done", {30'd0, reqDone}, 32'h0);
        check("rst_strobes", {30'd0, ramReadSignal, ramWriteSignal}, 32'h0);
        check("rst_addr", {16'd0, ramAddress}, 32'h0);
        check("rst_dout", {24'd0, reqDataOut}, 32'h0);
        check("rst_terr", {31'd0, timeoutErr}, 32'h0);
        tick();
        RST = 1'b1;
        tick();

        // req0 read, DMA answers in cycle 3
        reqRead    = 2'b01;
        reqAddress = 32'h0000_0010;
        tick();  // cycle 1
        check("rd_c1_strobe", {30'd0, ramReadSignal, ramWriteSignal}, 32'h2);
        check("rd_c1_addr", {16'd0, ramAddress}, 32'h0010);
        check("rd_c1_grant", {30'd0, grant}, 32'h1);
        tick();  // cycle 2
        check("rd_c2_strobe", {31'd0, ramReadSignal}, 32'h1);
        tick();  // cycle 3
        check("rd_c3_strobe", {31'd0, ramReadSignal}, 32'h1);
        check("rd_c3_nodone", {30'd0, reqDone}, 32'h0);
        ramDoneRead = 1'b1;
        ramDataOut  = 8'hA5;
        tick();  // cycle 4
        check("rd_c4_done", {30'd0, reqDone}, 32'h1);
        check("rd_c4_data", {24'd0, reqDataOut}, 32'hA5);
        check("rd_c4_strobe", {31'd0, ramReadSignal}, 32'h0);
        ramDoneRead = 1'b0;
        reqRead     = 2'b00;
        tick();  // cycle 5
        check("rd_c5_done", {30'd0, reqDone}, 32'h0);
        check("rd_c5_grant", {30'd0, grant}, 32'h0);

        // simultaneous writes from reset
        RST = 1'b0;
        tick();
        RST        = 1'b1;
        reqWrite   = 2'b11;
        reqAddress = 32'h0200_0100;
        reqDataIn  = 16'h2211;
        tick();
        check("wr_g0", {30'd0, grant}, 32'h1);
        check("wr_strobe0", {30'd0, ramReadSignal, ramWriteSignal}, 32'h1);
        check("wr_addr0", {16'd0, ramAddress}, 32'h0100);
        check("wr_data0", {24'd0, ramDataIn}, 32'h11);
        ramDoneRead = 1'b1;  // wrong kind of done
        tick();
        check("wr_wrongdone_strobe", {31'd0, ramWriteSignal}, 32'h1);
        check("wr_wrongdone_nodone", {30'd0, reqDone}, 32'h0);
        ramDoneRead  = 1'b0;
        ramDoneWrite = 1'b1;
        tick();
        check("wr_done0", {30'd0, reqDone}, 32'h1);
        check("wr_strobe_off", {31'd0, ramWriteSignal}, 32'h0);
        ramDoneWrite = 1'b0;
        reqWrite     = 2'b10;
        tick();
        check("wr_gap_grant", {30'd0, grant}, 32'h0);
        check("wr_hold_addr", {16'd0, ramAddress}, 32'h0100);
        tick();
        check("wr_g1", {30'd0, grant}, 32'h2);
        check("wr_addr1", {16'd0, ramAddress}, 32'h0200);
        check("wr_data1", {24'd0, ramDataIn}, 32'h22);
        ramDoneWrite = 1'b1;
        tick();
        check("wr_done1", {30'd0, reqDone}, 32'h2);
        check("wr_dout_hold", {24'd0, reqDataOut}, 32'h00);
        ramDoneWrite = 1'b0;
        reqWrite     = 2'b00;
        reqRead      = 2'b11;
        tick();  // IDLE, both pending

        // continuous requests alternate
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("rr_grant%0d", t), {30'd0, grant}, (t % 2 == 0) ? 32'h1 : 32'h2);
            if (grant == 2'b01) served0++;
            if (grant == 2'b10) served1++;
            ramDoneRead = 1'b1;
            ramDataOut  = 8'(t + 1);
            tick();
            check($sformatf("rr_done%0d", t), {30'd0, reqDone}, (t % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr_data%0d", t), {24'd0, reqDataOut}, 32'(t + 1));
            ramDoneRead = 1'b0;
            if (t == 7) reqRead = 2'b00;
            tick();
            check($sformatf("rr_idle%0d", t), {30'd0, grant}, 32'h0);
        end
        check("rr_served0", served0, 32'd4);
        check("rr_served1", served1, 32'd4);

        // stalled DMA: watchdog abort or indefinite wait
        reqRead    = 2'b01;
        reqAddress = 32'h0000_0077;
        tick();
        reqRead = 2'b00;
        tick();
        tick();
        tick();  // fourth BUSY cycle
        check("to_c4_strobe", {31'd0, ramReadSignal}, 32'h1);
        tick();
`ifdef RAM_ARB_TIMEOUT_EN
        check("to_strobe_off", {31'd0, ramReadSignal}, 32'h0);
        check("to_done", {30'd0, reqDone}, 32'h1);
        check("to_data", {24'd0, reqDataOut}, 32'h00);
        check("to_err", {31'd0, timeoutErr}, 32'h1);
        tick();
        check("to_err_sticky", {31'd0, timeoutErr}, 32'h1);
        check("to_idle", {30'd0, grant}, 32'h0);
`else
        tick();
        check("nto_strobe_held", {31'd0, ramReadSignal}, 32'h1);
        check("nto_nodone", {30'd0, reqDone}, 32'h0);
        check("nto_err", {31'd0, timeoutErr}, 32'h0);
        ramDoneRead = 1'b1;
        ramDataOut  = 8'h99;
        tick();
        check("nto_done", {30'd0, reqDone}, 32'h1);
        check("nto_data", {24'd0, reqDataOut}, 32'h99);
        ramDoneRead = 1'b0;
        tick();
`endif

        // req1 read+write together -> read only
        reqRead    = 2'b10;
        reqWrite   = 2'b10;
        reqAddress = 32'h1234_0000;
        reqDataIn  = 16'h5500;
        tick();
        check("rw_strobes", {30'd0, ramReadSignal, ramWriteSignal}, 32'h2);
        check("rw_addr", {16'd0, ramAddress}, 32'h1234);
        check("rw_grant", {30'd0, grant}, 32'h2);

        // asynchronous reset in BUSY
        #2;
        RST = 1'b0;
        #1;
        check("ar_strobe", {31'd0, ramReadSignal}, 32'h0);
        check("ar_grant", {30'd0, grant}, 32'h0);
        check("ar_addr", {16'd0, ramAddress}, 32'h0);
        reqRead  = 2'b00;
        reqWrite = 2'b00;
        @(negedge clk);
        RST = 1'b1;
        tick();
        tick();
        check("ar_nodone", {30'd0, reqDone}, 32'h0);
        reqWrite   = 2'b11;
        reqAddress = 32'h0043_0042;
        reqDataIn  = 16'h8877;
        tick();
        check("ar_new_grant", {30'd0, grant}, 32'h1);
        check("ar_new_strobe", {30'd0, ramReadSignal, ramWriteSignal}, 32'h1);
        check("ar_new_data", {24'd0, ramDataIn}, 32'h77);
        check("ar_terr", {31'd0, timeoutErr}, 32'h0);
        ramDoneWrite = 1'b1;
        reqWrite     = 2'b00;
        tick();
        check("ar_new_done", {30'd0, reqDone}, 32'h1);
        ramDoneWrite = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
